gpio_regblk: RTL
================

# gpio_regblk

Parametrised second-generation GPIO register block on the peripheral local bus. It provides a configurable pin count with per-pin output enable, atomic set/clear of the output register, a two-stage input synchroniser, and per-pin rising/falling edge interrupts with sticky write-1-to-clear status. It also keeps the digital-filter and reference-clock-divider settings consumed by the GPIO function block.

## Interface
- NPIN, 16, number of GPIO pins, 1..32; unused bits of every register read 0 and ignore writes
- AWIDTH, from core_general.vh, local bus address width
- XLEN, from core_general.vh, bus data width (32)
- clk  in  1  global clock
- rst_n  in  1  global reset; reset is asynchronous and active-low
- sel  in  1  block select
- addr  in  AWIDTH  byte address; only addr[7:2] decoded
- we  in  3  write enable; we[2]=write, we[1:0]: 10 word, 01 halfword, 00 byte
- wdata  in  XLEN  write data
- rdata  out  XLEN  read data
- gpio_in  in  NPIN  raw pin input (asynchronous)
- gpio_out  out  NPIN  output data
- gpio_oe  out  NPIN  output enable, 1=drive
- dflt_st  out  8  digital filter setting
- refclk_st  out  8  divided-clock setting
- irq  out  1  level interrupt, |(IRQ_STAT & IRQ_EN)

## Operation
- Register map (word offsets):
  - 0x00 CTRL RW: [7:0] dflt_st, [15:8] refclk_st
  - 0x04 OUT RW
  - 0x08 OUT_SET WO: OUT |= wdata
  - 0x0C OUT_CLR WO: OUT &= ~wdata
  - 0x10 OE RW
  - 0x14 IN RO: synchronised pin state
  - 0x18 RISE_EN RW
  - 0x1C FALL_EN RW
  - 0x20 IRQ_STAT W1C
  - 0x24 IRQ_EN RW
- Byte lanes:
  - Byte write updates bits [7:0] only; halfword updates [15:0]; word updates [31:0].
  - addr[1:0] is ignored.
- Reads:
  - rdata is combinational from sel/addr.
  - Reads return 0 when sel=0, at an unmapped offset, and for the WO registers.
  - Reads have no side effects.
- Input path: gpio_in feeds sync1, then sync2 (which is IN), then prev.
- Edge event per pin:
  - Rising event = sync2 & ~prev & RISE_EN.
  - Falling event = ~sync2 & prev & FALL_EN.
  - Either event sets IRQ_STAT.
- Simultaneous edge event and W1C on the same bit: the set wins, so the bit stays 1.
- Post-reset warm-up:
  - A 2-bit counter counts up after reset; edge events are masked until it saturates at 3.
  - Pins held high through reset therefore never raise a spurious rising event.
- Disabling RISE_EN/FALL_EN/IRQ_EN does not clear IRQ_STAT.

## Timing
- Reset value of every register and output is 0: gpio_out, gpio_oe, dflt_st, refclk_st, irq, sync/prev flops, warm-up counter.
- Register writes take effect at the clock edge on which sel & we[2]; the new value is visible on the outputs and on reads from the following cycle.
- Input latency:
  - gpio_in stable before edge k appears in IN after edge k+1.
  - IRQ_STAT bit sets at edge k+2.
  - irq rises in the same cycle, since it is combinational from the registers.
- Pulses shorter than one clk period may be missed; this is not required to be caught.
- Asserting rst_n low mid-operation clears all state immediately and restarts warm-up.

## Configuration
- GPIO_IRQ_EN defined: RISE_EN, FALL_EN, IRQ_STAT, IRQ_EN, edge logic and warm-up counter are present.
- GPIO_IRQ_EN undefined:
  - Offsets 0x18–0x24 read 0 and ignore writes.
  - irq is tied 0.
  - The synchroniser and IN remain.

## Structure
- Package gpio_pkg holds:
  - Register offset constants (GPIO_OFS_CTRL … GPIO_OFS_IRQ_EN).
  - we encoding constants (WE_WORD=3'b110, WE_HALF=3'b101, WE_BYTE=3'b100).
- One sub-module, gpio_edge_det:
  - Parameter NPIN.
  - Contains the sync1/sync2/prev flops, the warm-up counter and the rise/fall event outputs.
  - Instantiated only under GPIO_IRQ_EN; IN is taken from a bare synchroniser otherwise.

## Test plan
- Reset, then read all offsets → all 0; irq=0, gpio_oe=0.
- Word write 0x04=0x00FF, then 0x08=0x0F00, then 0x0C=0x000F → gpio_out=0x0FF0 and OUT reads 0x0FF0.
- Byte write (we=100) 0x10 with wdata=0xABCD → OE reads 0x00CD; a following halfword write of 0x1234 → OE reads 0x1234.
- Rising edge, with RISE_EN=0x0001 and IRQ_EN=0x0001:
  - Drive gpio_in[0] 0→1 before edge k → IN[0]=1 after k+1, IRQ_STAT=0x0001 and irq=1 at k+2.
  - Write 0x20=0x0001 → irq=0 on the next cycle.
- Set vs. clear collision: falling event on pin 3 in the same cycle as a W1C of bit 3 → IRQ_STAT[3] stays 1. With gpio_in=0xFFFF held through reset and RISE_EN=0xFFFF → IRQ_STAT remains 0.
- Build without GPIO_IRQ_EN, write 0x24=0xFFFF and toggle pins → reads of 0x24 return 0 and irq stays 0.

Source files
------------

// File: rtl/gpio_pkg.sv
// gpio_pkg: register offsets, bus write encodings and byte-lane mask helper for gpio_regblk
package gpio_pkg;
  localparam logic [7:0] GPIO_OFS_CTRL     = 8'h00;
  localparam logic [7:0] GPIO_OFS_OUT      = 8'h04;
  localparam logic [7:0] GPIO_OFS_OUT_SET  = 8'h08;
  localparam logic [7:0] GPIO_OFS_OUT_CLR  = 8'h0C;
  localparam logic [7:0] GPIO_OFS_OE       = 8'h10;
  localparam logic [7:0] GPIO_OFS_IN       = 8'h14;
  localparam logic [7:0] GPIO_OFS_RISE_EN  = 8'h18;
  localparam logic [7:0] GPIO_OFS_FALL_EN  = 8'h1C;
  localparam logic [7:0] GPIO_OFS_IRQ_STAT = 8'h20;
  localparam logic [7:0] GPIO_OFS_IRQ_EN   = 8'h24;
  localparam logic [2:0] WE_WORD = 3'b110;
  localparam logic [2:0] WE_HALF = 3'b101;
  localparam logic [2:0] WE_BYTE = 3'b100;
  function automatic logic [31:0] lane_mask(input logic [2:0] w);
    return ({1'b1, w[1:0]} == WE_WORD) ? 32'hFFFF_FFFF :
           ({1'b1, w[1:0]} == WE_HALF) ? 32'h0000_FFFF : 32'h0000_00FF;
  endfunction
endpackage

// File: rtl/gpio_edge_det.sv
// gpio_edge_det: two-stage pin synchroniser with post-reset warm-up and masked rise/fall events
module gpio_edge_det #(
  parameter int NPIN = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NPIN-1:0] gpio_in,
  input  logic [NPIN-1:0] rise_en,
  input  logic [NPIN-1:0] fall_en,
  output logic [NPIN-1:0] sync,
  output logic [NPIN-1:0] rise,
  output logic [NPIN-1:0] fall
);
  logic [NPIN-1:0] sync1, prev;
  logic [1:0] warm;
  logic live;
  assign live = &warm;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync1 <= '0;
      sync <= '0;
      prev <= '0;
      warm <= '0;
    end else begin
      sync1 <= gpio_in;
      sync <= sync1;
      prev <= sync;
      warm <= live ? warm : warm + 2'd1;
    end
  always_comb begin
    rise = live ? sync & ~prev & rise_en : '0;
    fall = live ? ~sync & prev & fall_en : '0;
  end
endmodule

// File: rtl/gpio_regblk.sv
// gpio_regblk: GPIO register block with atomic set/clear, input sync and edge IRQs under GPIO_IRQ_EN
module gpio_regblk
  import gpio_pkg::*;
#(
  parameter int NPIN = 16,
  parameter int AWIDTH = 16,
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sel,
  input  logic [AWIDTH-1:0] addr,
  input  logic [2:0]        we,
  input  logic [XLEN-1:0]   wdata,
  output logic [XLEN-1:0]   rdata,
  input  logic [NPIN-1:0]   gpio_in,
  output logic [NPIN-1:0]   gpio_out,
  output logic [NPIN-1:0]   gpio_oe,
  output logic [7:0]        dflt_st,
  output logic [7:0]        refclk_st,
  output logic              irq
);
  logic [15:0] ctrl;
  logic [NPIN-1:0] sync_in, mk, wd;
  logic [31:0] lm;
  logic [7:0] ofs;
  logic wr, unused_bits;
  assign ofs = {addr[7:2], 2'b00};
  assign wr = sel & we[2];
  assign lm = lane_mask(we);
  assign mk = lm[NPIN-1:0];
  assign wd = wdata[NPIN-1:0] & mk;
  assign dflt_st = ctrl[7:0];
  assign refclk_st = ctrl[15:8];
  assign unused_bits = ^{addr, wdata, lm};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ctrl <= '0;
      gpio_out <= '0;
      gpio_oe <= '0;
    end else if (wr) begin
      if (ofs == GPIO_OFS_CTRL) ctrl <= (ctrl & ~lm[15:0]) | (wdata[15:0] & lm[15:0]);
      if (ofs == GPIO_OFS_OUT) gpio_out <= (gpio_out & ~mk) | wd;
      if (ofs == GPIO_OFS_OUT_SET) gpio_out <= gpio_out | wd;
      if (ofs == GPIO_OFS_OUT_CLR) gpio_out <= gpio_out & ~wd;
      if (ofs == GPIO_OFS_OE) gpio_oe <= (gpio_oe & ~mk) | wd;
    end
`ifdef GPIO_IRQ_EN
  logic [NPIN-1:0] rise_en, fall_en, irq_stat, irq_en, rise, fall;
  gpio_edge_det #(.NPIN(NPIN)) u_edge (
    .clk(clk),
    .rst_n(rst_n),
    .gpio_in(gpio_in),
    .rise_en(rise_en),
    .fall_en(fall_en),
    .sync(sync_in),
    .rise(rise),
    .fall(fall)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rise_en <= '0;
      fall_en <= '0;
      irq_en <= '0;
      irq_stat <= '0;
    end else begin
      if (wr && ofs == GPIO_OFS_RISE_EN) rise_en <= (rise_en & ~mk) | wd;
      if (wr && ofs == GPIO_OFS_FALL_EN) fall_en <= (fall_en & ~mk) | wd;
      if (wr && ofs == GPIO_OFS_IRQ_EN) irq_en <= (irq_en & ~mk) | wd;
      irq_stat <= (irq_stat & ~((wr && ofs == GPIO_OFS_IRQ_STAT) ? wd : '0)) | rise | fall;
    end
  assign irq = |(irq_stat & irq_en);
`else
  logic [NPIN-1:0] sync1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync1 <= '0;
      sync_in <= '0;
    end else begin
      sync1 <= gpio_in;
      sync_in <= sync1;
    end
  assign irq = 1'b0;
`endif
  always_comb begin
    rdata = '0;
    if (sel)
      case (ofs)
        GPIO_OFS_CTRL:     rdata = XLEN'(ctrl);
        GPIO_OFS_OUT:      rdata = XLEN'(gpio_out);
        GPIO_OFS_OE:       rdata = XLEN'(gpio_oe);
        GPIO_OFS_IN:       rdata = XLEN'(sync_in);
`ifdef GPIO_IRQ_EN
        GPIO_OFS_RISE_EN:  rdata = XLEN'(rise_en);
        GPIO_OFS_FALL_EN:  rdata = XLEN'(fall_en);
        GPIO_OFS_IRQ_STAT: rdata = XLEN'(irq_stat);
        GPIO_OFS_IRQ_EN:   rdata = XLEN'(irq_en);
`endif
        default:           rdata = '0;
      endcase
  end
endmodule
